// File: rtl/vliw_spi_pkg.sv
// Shared definitions for the vliw_spi transaction sequencer.
//   xfer_state_t : sequencer states (also exported on the debug port)
//   DUMMY_BYTE   : byte sent while clocking in read data or a dummy cycle
//   WD_LIMIT     : cycles waited for the engine's busy before a start is reissued
package vliw_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT_RISE,
        WAIT_FALL,
        DELIVER,
        NEXT,
        HOLD
    } xfer_state_t;

    localparam logic [7:0] DUMMY_BYTE = 8'h00;
    localparam int         WD_LIMIT   = 4;

endpackage

// File: rtl/vliw_spi_xfer_ctrl_if.sv
// Host-side bundle of vliw_spi_xfer_ctrl: request channel, read-data stream
// and the end-of-transfer pulse.
//   master : the host (drives requests, accepts read bytes)
//   slave  : the sequencer
// Optional macro VLIW_SPI_XFER_FAST_READ_EN adds fast (request qualifier)
// and err (watchdog failure flag).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only while the sequencer is idle.
// rd_valid, once raised, holds itself and rd_data unchanged until the edge
// where rd_ready is also high.
interface vliw_spi_xfer_ctrl_if #(
    parameter int LEN_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_cmd;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             done;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
    logic             fast;
    logic             err;

    modport master (
        output req_valid, req_cmd, req_addr, req_len, rd_ready, fast,
        input  req_ready, rd_data, rd_valid, done, err
    );
    modport slave (
        input  req_valid, req_cmd, req_addr, req_len, rd_ready, fast,
        output req_ready, rd_data, rd_valid, done, err
    );
`else
    modport master (
        output req_valid, req_cmd, req_addr, req_len, rd_ready,
        input  req_ready, rd_data, rd_valid, done
    );
    modport slave (
        input  req_valid, req_cmd, req_addr, req_len, rd_ready,
        output req_ready, rd_data, rd_valid, done
    );
`endif
endinterface

// File: rtl/vliw_spi_cs_timer.sv
// Loadable down-counter timing the chip-select setup and hold windows.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : number of cycles the window lasts (>=1)
//   last      : high in the final cycle of the window
module vliw_spi_cs_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == W'(1));
endmodule

// File: rtl/vliw_spi_xfer_ctrl.sv
// Transaction sequencer above the vliw_spi byte engine. Accepts a request
// (command, address, read length), frames it with chip-select, feeds the
// engine one byte at a time through start/busy and streams read bytes to
// the host.
//   clk, rst   : clock, synchronous active-high reset
//   host       : request / read stream / done (vliw_spi_xfer_ctrl_if.slave)
//   spi_cs_n   : chip select, active-low
//   spi_start  : one-cycle start pulse to the engine
//   spi_din    : byte to transmit, held from start until busy falls
//   spi_dout   : byte received by the engine, valid when busy falls
//   spi_busy   : engine busy
//   state_dbg  : current sequencer state
// Optional macro VLIW_SPI_XFER_FAST_READ_EN: fast request bit inserts one
// dummy byte after the address; err flags a watchdog failure with done.
module vliw_spi_xfer_ctrl
    import vliw_spi_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int LEN_W      = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vliw_spi_xfer_ctrl_if.slave  host,
    output logic                 spi_cs_n,
    output logic                 spi_start,
    output logic [7:0]           spi_din,
    input  logic [7:0]           spi_dout,
    input  logic                 spi_busy,
    output xfer_state_t          state_dbg
);
    // One extra bit so the byte count of a maximum-length read cannot wrap.
    localparam int IW = LEN_W + 1;

    xfer_state_t      state;
    logic [7:0]       cmd_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [IW-1:0]    idx;
    logic [1:0]       wd_cnt;
    logic             retried;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic             done_q;
    logic [IW-1:0]    hdr_bytes;
    logic [IW-1:0]    total_bytes;
    logic [IW-1:0]    idx_nxt;
    logic             timer_load;
    logic [7:0]       timer_val;
    logic             timer_last;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
    logic             fast_q;
    logic             wd_fail;
    logic             err_q;
`endif

    // Byte i of the frame: command, address MSB-first, then dummy bytes.
    function automatic logic [7:0] tx_byte(input logic [IW-1:0] i,
                                           input logic [7:0]    cmd,
                                           input logic [23:0]   addr);
        logic [23:0] sh;
        sh = addr >> (8 * (ADDR_BYTES - int'(i)));
        if (i == '0) return cmd;
        if (int'(i) <= ADDR_BYTES) return sh[7:0];
        return DUMMY_BYTE;
    endfunction

`ifdef VLIW_SPI_XFER_FAST_READ_EN
    assign hdr_bytes = IW'(1 + ADDR_BYTES) + IW'(fast_q);
`else
    assign hdr_bytes = IW'(1 + ADDR_BYTES);
`endif
    assign total_bytes = hdr_bytes + IW'(len_q);
    assign idx_nxt     = idx + 1'b1;

    // The timer reloads in every state except the two it times, so it is
    // always armed with the right window length on entry to SETUP or HOLD.
    assign timer_load = (state != SETUP) && (state != HOLD);
    assign timer_val  = (state == IDLE) ? 8'(CS_SETUP) : 8'(CS_HOLD);

    vliw_spi_cs_timer #(.W(8)) u_cs_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            spi_cs_n   <= 1'b1;
            spi_start  <= 1'b0;
            spi_din    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            idx        <= '0;
            wd_cnt     <= '0;
            retried    <= 1'b0;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
            fast_q     <= 1'b0;
            wd_fail    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            spi_start <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.req_valid) begin
                        cmd_q    <= host.req_cmd;
                        addr_q   <= host.req_addr;
                        len_q    <= host.req_len;
                        idx      <= '0;
                        spi_cs_n <= 1'b0;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
                        fast_q   <= host.fast;
                        wd_fail  <= 1'b0;
                        err_q    <= 1'b0;
`endif
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_last) begin
                        spi_start <= 1'b1;
                        spi_din   <= tx_byte(idx, cmd_q, addr_q);
                        retried   <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (spi_busy) begin
                        state <= WAIT_FALL;
                    end else if (wd_cnt == 2'(WD_LIMIT - 1)) begin
                        // Engine missed the start: retry once with the same
                        // byte, then give up and close the frame.
                        if (!retried) begin
                            retried   <= 1'b1;
                            spi_start <= 1'b1;
                            state     <= ISSUE;
                        end else begin
`ifdef VLIW_SPI_XFER_FAST_READ_EN
                            wd_fail <= 1'b1;
`endif
                            state   <= HOLD;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                WAIT_FALL: begin
                    if (!spi_busy) begin
                        if (idx >= hdr_bytes) begin
                            rd_data_q  <= spi_dout;
                            rd_valid_q <= 1'b1;
                            state      <= DELIVER;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                DELIVER: begin
                    if (host.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state      <= NEXT;
                    end
                end
                NEXT: begin
                    idx <= idx_nxt;
                    if (idx_nxt == total_bytes) begin
                        state <= HOLD;
                    end else begin
                        spi_start <= 1'b1;
                        spi_din   <= tx_byte(idx_nxt, cmd_q, addr_q);
                        retried   <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                HOLD: begin
                    if (timer_last) begin
                        spi_cs_n <= 1'b1;
                        done_q   <= 1'b1;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
                        err_q    <= wd_fail;
`endif
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.req_ready = (state == IDLE);
    assign host.rd_data   = rd_data_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.done      = done_q;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
    assign host.err       = err_q;
`endif
    assign state_dbg      = state;
endmodule

// File: tb/tb_vliw_spi_xfer_ctrl.sv
// Bench for vliw_spi_xfer_ctrl: one instance with 3 address bytes driven by
// a randomized engine/host model, one with 0 address bytes for the
// command-only frame and CS timing.
module tb_vliw_spi_xfer_ctrl;
    import vliw_spi_pkg::*;

    localparam int LEN_W    = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (3 address bytes) ----------------
    vliw_spi_xfer_ctrl_if #(.LEN_W(LEN_W)) host_a ();
    logic        a_cs_n, a_start, a_busy;
    logic [7:0]  a_din, a_dout;
    xfer_state_t a_state;

    vliw_spi_xfer_ctrl #(.ADDR_BYTES(3), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut_a (
        .clk(clk), .rst(rst), .host(host_a),
        .spi_cs_n(a_cs_n), .spi_start(a_start), .spi_din(a_din),
        .spi_dout(a_dout), .spi_busy(a_busy), .state_dbg(a_state)
    );

    // ---------------- DUT B (command only) ----------------
    vliw_spi_xfer_ctrl_if #(.LEN_W(LEN_W)) host_b ();
    logic        b_cs_n, b_start, b_busy;
    logic [7:0]  b_din, b_dout;
    xfer_state_t b_state;

    vliw_spi_xfer_ctrl #(.ADDR_BYTES(0), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut_b (
        .clk(clk), .rst(rst), .host(host_b),
        .spi_cs_n(b_cs_n), .spi_start(b_start), .spi_din(b_din),
        .spi_dout(b_dout), .spi_busy(b_busy), .state_dbg(b_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_mosi[$];
    logic [7:0] act_mosi[$];
    logic [7:0] exp_q[$];
    logic [7:0] act_rd[$];
    logic [7:0] b_mosi[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- engine models ----------------
    int cyc = 0;
    int viol = 0;
    int a_ph = 0, a_left = 0, a_busy_len = 0, a_ign = 0, a_pos = 0, a_hdr = 4;
    int a_start_cnt = 0, a_xfer_starts = 0, a_last_start = 0, a_gap12 = 0;
    logic [7:0] a_din_lat, a_resp;
    int b_ph = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            a_busy <= 1'b0;
            a_dout <= 8'h00;
            a_ph = 0;
            b_busy <= 1'b0;
            b_dout <= 8'h00;
            b_ph = 0;
        end else begin
            // Engine A: busy rises two cycles after start, lasts 1..3 cycles,
            // received byte appears as busy falls.
            case (a_ph)
                1: begin
                    a_busy <= 1'b1;
                    a_left = (a_busy_len > 0) ? a_busy_len : $urandom_range(1, 3);
                    a_ph = 2;
                end
                2: begin
                    a_left--;
                    if (a_left == 0) begin
                        a_resp = 8'($urandom);
                        a_busy <= 1'b0;
                        a_dout <= a_resp;
                        if (a_pos >= a_hdr) exp_q.push_back(a_resp);
                        a_pos++;
                        if (a_din != a_din_lat) viol++;
                        a_ph = 0;
                    end
                end
                default: ;
            endcase
            if (a_start) begin
                a_start_cnt++;
                a_xfer_starts++;
                if (a_xfer_starts == 2) a_gap12 = cyc - a_last_start;
                a_last_start = cyc;
                if (a_ph != 0) viol++;
                if (a_ign > 0) begin
                    a_ign--;
                end else begin
                    act_mosi.push_back(a_din);
                    a_din_lat = a_din;
                    a_ph = 1;
                end
            end
            // Engine B: fixed one-cycle busy.
            case (b_ph)
                1: begin b_busy <= 1'b1; b_ph = 2; end
                2: begin b_busy <= 1'b0; b_dout <= 8'h77; b_ph = 0; end
                default: ;
            endcase
            if (b_start) b_ph = 1;
        end
    end

    // ---------------- host models / monitors ----------------
    int   ready_mode = 0;
    int   stall_left = 0, stall_cycles = 0;
    int   a_done_cnt = 0;
    logic pend_valid = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic prev_cs_a = 1'b1;
    logic expect_abort = 1'b0;

    always @(negedge clk) begin
        logic nr;
        nr = 1'b1;
        if (ready_mode == 1) nr = 1'($urandom_range(0, 1));
        if (ready_mode == 2 && host_a.rd_valid && act_rd.size() == 1 && stall_left > 0) begin
            nr = 1'b0;
            stall_left--;
            stall_cycles++;
        end
        if (pend_valid && (!host_a.rd_valid || host_a.rd_data != pend_data)) viol++;
        if (host_a.rd_valid && nr) act_rd.push_back(host_a.rd_data);
        pend_valid = host_a.rd_valid && !nr;
        pend_data  = host_a.rd_data;
        if (a_start && (a_cs_n || a_busy || host_a.rd_valid)) viol++;
        if (host_a.rd_valid && a_cs_n) viol++;
        if (!prev_cs_a && a_cs_n && !host_a.done && !expect_abort) viol++;
        prev_cs_a = a_cs_n;
        if (host_a.done) a_done_cnt++;
        host_a.rd_ready = nr;
    end

    int b_done_cnt = 0, b_rdv_cnt = 0;
    int b_cs_fall = 0, b_start_cyc = 0, b_fall = 0, b_done_cyc = 0;
    logic b_prev_cs = 1'b1, b_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (b_prev_cs && !b_cs_n) b_cs_fall = cyc;
        if (b_start) begin
            b_mosi.push_back(b_din);
            b_start_cyc = cyc;
        end
        if (b_prev_busy && !b_busy) b_fall = cyc;
        if (host_b.done) begin
            b_done_cnt++;
            b_done_cyc = cyc;
        end
        if (host_b.rd_valid) b_rdv_cnt++;
        b_prev_cs   = b_cs_n;
        b_prev_busy = b_busy;
        host_b.rd_ready = 1'b1;
    end

    // ---------------- driver task ----------------
    task automatic run_a(input logic [7:0] cmd, input logic [23:0] addr, input int len,
                         input logic fast, input int mode, input int ign);
        int n, d0, v0, s0, nb;
        exp_mosi.delete(); act_mosi.delete(); exp_q.delete(); act_rd.delete();
        if (ign < 2) begin
            exp_mosi.push_back(cmd);
            for (int k = 2; k >= 0; k--) exp_mosi.push_back(addr[8*k +: 8]);
            if (fast) exp_mosi.push_back(8'h00);
            for (int k = 0; k < len; k++) exp_mosi.push_back(8'h00);
        end
        a_hdr = 4 + int'(fast);
        a_pos = 0; a_ign = ign; a_xfer_starts = 0; a_gap12 = 0;
        ready_mode = mode; stall_left = 20; stall_cycles = 0;
        d0 = a_done_cnt; v0 = viol; s0 = a_start_cnt;
        host_a.req_cmd  = cmd;
        host_a.req_addr = addr;
        host_a.req_len  = LEN_W'(len);
`ifdef VLIW_SPI_XFER_FAST_READ_EN
        host_a.fast     = fast;
`endif
        host_a.req_valid = 1'b1;
        check("req_ready_idle", host_a.req_ready, 1);
        @(negedge clk);
        host_a.req_valid = 1'b0;
        check("cs_low_after_req", a_cs_n, 0);
        check("req_ready_busy", host_a.req_ready, 0);
        n = 0;
        while (a_done_cnt == d0 && n < 200 + len * 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", a_done_cnt != d0, 1);
        repeat (3) @(negedge clk);
        check("done_pulses", a_done_cnt - d0, 1);
        check("cs_high_after", a_cs_n, 1);
        check("mosi_count", act_mosi.size(), exp_mosi.size());
        nb = (act_mosi.size() < exp_mosi.size()) ? act_mosi.size() : exp_mosi.size();
        for (int k = 0; k < nb; k++) check("mosi_byte", act_mosi[k], exp_mosi[k]);
        check("rd_count", act_rd.size(), (ign < 2) ? len : 0);
        nb = (act_rd.size() < exp_q.size()) ? act_rd.size() : exp_q.size();
        for (int k = 0; k < nb; k++) check("rd_byte", act_rd[k], exp_q[k]);
        check("start_count", a_start_cnt - s0, exp_mosi.size() + ign);
        if (ign > 0) check("wd_reissue_gap", a_gap12, 5);
        if (mode == 2 && len >= 2) check("stall_cycles", stall_cycles, 20);
        check("protocol_viol", viol - v0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, d0;
        host_a.req_valid = 1'b0; host_a.req_cmd = '0; host_a.req_addr = '0; host_a.req_len = '0;
        host_b.req_valid = 1'b0; host_b.req_cmd = '0; host_b.req_addr = '0; host_b.req_len = '0;
`ifdef VLIW_SPI_XFER_FAST_READ_EN
        host_a.fast = 1'b0;
        host_b.fast = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", a_cs_n, 1);
        check("rst_start", a_start, 0);
        check("rst_din", a_din, 0);
        check("rst_rd_valid", host_a.rd_valid, 0);
        check("rst_rd_data", host_a.rd_data, 0);
        check("rst_done", host_a.done, 0);
        check("rst_req_ready", host_a.req_ready, 1);
        check("rst_state", a_state, IDLE);
        check("rst_b_cs_n", b_cs_n, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed read: 03 12 34 56 00 00
        run_a(8'h03, 24'h123456, 2, 1'b0, 0, 0);
        // Stall on the second read byte
        run_a(8'h0B, 24'h00FF01, 3, 1'b0, 2, 0);
        // Header-only frame
        run_a(8'h02, 24'hABCDEF, 0, 1'b0, 0, 0);
        // Watchdog: one missed start, then two
        run_a(8'h03, 24'h654321, 2, 1'b0, 1, 1);
        run_a(8'h03, 24'h111111, 2, 1'b0, 0, 2);
`ifdef VLIW_SPI_XFER_FAST_READ_EN
        check("err_set", host_a.err, 1);
        run_a(8'h0B, 24'hAABBCC, 1, 1'b1, 0, 0);
        check("err_clear", host_a.err, 0);
`endif
        // Randomized frames
        for (int t = 0; t < 10; t++)
            run_a(8'($urandom), 24'($urandom), $urandom_range(0, 6), 1'b0, $urandom_range(0, 1), 0);
        // Longest read length
        run_a(8'h03, 24'h000000, 255, 1'b0, 0, 0);

        // Reset while the first address byte is in flight
        a_busy_len = 3; ready_mode = 0; a_xfer_starts = 0; a_ign = 0; a_pos = 0; a_hdr = 4;
        d0 = a_done_cnt;
        host_a.req_cmd = 8'h03; host_a.req_addr = 24'h123456; host_a.req_len = 8'd2;
        host_a.req_valid = 1'b1;
        @(negedge clk);
        host_a.req_valid = 1'b0;
        n = 0;
        while (!(a_xfer_starts == 2 && a_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_addr", a_xfer_starts == 2 && a_busy, 1);
        @(negedge clk);
        expect_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_high", a_cs_n, 1);
        check("abort_req_ready", host_a.req_ready, 1);
        check("abort_no_done", host_a.done, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_done_cnt", a_done_cnt - d0, 0);
        expect_abort = 1'b0;
        a_busy_len = 0;
        run_a(8'h9F, 24'h010203, 2, 1'b0, 1, 0);

        // Command-only instance: single 0x06, no read data
        host_b.req_cmd = 8'h06; host_b.req_addr = 24'hFFFFFF; host_b.req_len = '0;
        host_b.req_valid = 1'b1;
        @(negedge clk);
        host_b.req_valid = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("b_done_cnt", b_done_cnt, 1);
        check("b_mosi_count", b_mosi.size(), 1);
        if (b_mosi.size() > 0) check("b_mosi_byte", b_mosi[0], 8'h06);
        check("b_no_rd_valid", b_rdv_cnt, 0);
        check("b_cs_setup", b_start_cyc - b_cs_fall, CS_SETUP);
        check("b_cs_hold", b_done_cyc - b_fall, CS_HOLD + 2);
        check("b_cs_high", b_cs_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vliw_spi_xfer_ctrl.md
Name: vliw_spi_xfer_ctrl

Overview:
- Transaction sequencer sitting directly above the vliw_spi byte engine.
- Accepts a host request (command, address, read length) and drives chip-select.
- Issues command, address bytes and dummy/read bytes one at a time through the engine's start/busy handshake.
- Streams received bytes to the host with a valid/ready handshake. Used for SPI flash / peripheral reads from the VLIW core.

Parameters:
- ADDR_BYTES, 3, number of address bytes sent MSB-first after the command (0..3; 0 = command only).
- LEN_W, 8, width of the read-length field.
- CS_SETUP, 2, clk cycles CS low before first start (>=1).
- CS_HOLD, 2, clk cycles after last byte before CS high (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_cmd  in  8  command byte
- req_addr  in  24  address; low ADDR_BYTES*8 bits used
- req_len  in  LEN_W  bytes to read after the header (0 = write header only)
- rd_data  out  8  received byte
- rd_valid  out  1  rd_data valid; held until rd_ready
- rd_ready  in  1  host accepts byte
- done  out  1  one-cycle pulse when CS returns high
- spi_cs_n  out  1  chip select, active-low
- spi_start  out  1  one-cycle start pulse to byte engine
- spi_din  out  8  byte to transmit, stable from start until busy falls
- spi_dout  in  8  byte received from engine
- spi_busy  in  1  engine busy

Behaviour:
- Reset: spi_cs_n=1; spi_start=0; spi_din=0; rd_valid=0; rd_data=0; done=0; state=IDLE.
- Reset mid-transfer aborts immediately: CS high next edge, no done pulse.
- IDLE: req_ready=1. On req_valid, latch cmd/addr/len, set byte index=0, drop CS, go to SETUP.
- SETUP: count CS_SETUP cycles, then go to ISSUE.
- ISSUE: assert spi_start for exactly one cycle with spi_din per the transmit byte order, then go to WAIT_RISE.
  - Transmit byte order: cmd, then addr bytes MSB-first, then 0x00 for each read byte.
- WAIT_RISE: wait for spi_busy=1 (engine asserts busy two cycles after start).
- WAIT_FALL: wait for spi_busy=0; spi_dout is valid in that cycle.
  - Header byte received data is discarded.
  - If the byte was a read byte: capture spi_dout into rd_data, set rd_valid, go to DELIVER.
  - Otherwise go to NEXT.
- DELIVER: hold rd_valid/rd_data until rd_ready=1. Clear rd_valid on the accepting edge, go to NEXT. CS stays low while stalled.
- NEXT: increment index.
  - Index == 1+ADDR_BYTES+len: go to HOLD.
  - Otherwise: go to ISSUE.
- HOLD: count CS_HOLD cycles, raise CS, pulse done, go to IDLE.
- Minimum latency between read-byte starts is 3 cycles plus engine time; no start is ever issued while spi_busy=1.
- Index counter width: LEN_W+1 bits, so len = 2^LEN_W-1 does not wrap.
- req_valid outside IDLE is ignored (req_ready=0).
- Watchdog: if WAIT_RISE lasts 4 cycles without busy, reissue start once. A second failure goes to HOLD and sets done (error is not flagged; see optional feature).

Optional Feature:
- Macro VLIW_SPI_XFER_FAST_READ_EN.
- Defined:
  - Adds input fast (1 bit, latched with the request).
  - When fast=1, one 0x00 dummy byte is inserted after the address bytes. Its received data is discarded and the total count becomes 2+ADDR_BYTES+len.
  - Adds output err (1 bit, set with done on watchdog failure, cleared on next request).
- Undefined: no fast/err ports; header is exactly 1+ADDR_BYTES bytes.

Decomposition:
- Shared package vliw_spi_pkg holds:
  - the state enum (IDLE, SETUP, ISSUE, WAIT_RISE, WAIT_FALL, DELIVER, NEXT, HOLD);
  - the dummy byte constant 0x00;
  - the watchdog limit constant 4.
- One sub-module, vliw_spi_cs_timer: loadable down-counter shared by SETUP and HOLD. It is reused and not duplicated.
- The byte engine is instantiated by the parent, not inside this block.

Test Plan:
- cmd=0x03, addr=0x123456, len=2, engine model returns 0xA5,0x5A, rd_ready=1:
  - MOSI bytes 03,12,34,56,00,00;
  - rd_data 0xA5 then 0x5A;
  - one done pulse; CS low for the whole transfer.
- len=0, cmd=0x06, ADDR_BYTES=0: single byte 0x06 sent, no rd_valid, done after CS_HOLD.
- len=3 with rd_ready held low 20 cycles on byte 2:
  - rd_valid/rd_data stable;
  - no spi_start during the stall;
  - CS stays low;
  - 3 bytes delivered in order.
- rst asserted while in WAIT_FALL of the address phase: CS high next cycle, req_ready=1, no done pulse.
- Engine stub ignores the first start: start reissued after 4 cycles, transfer completes normally. Engine ignores both starts: done pulses, err=1 when VLIW_SPI_XFER_FAST_READ_EN.
- With VLIW_SPI_XFER_FAST_READ_EN, fast=1, cmd=0x0B, len=1: MOSI 0B,AA,BB,CC,00,00. Only the last byte is delivered.
